river_scroll_ctrl: RTL and testbench
====================================

# river_scroll_ctrl

Sequences the river layer's scroll. It turns a once-per-frame `frame_tick` and player speed commands into bursts of single-cycle `update_signal` pulses for the river drawer: one pulse is one scroll row. It also tracks stage distance, handles pause and crash slow-down, and reports stage completion. It sits between the game-logic / input block and the river drawer. Its `update_signal` output drives the drawer's `update_signal` input directly.

## Interface
Parameters:
- MAX_SPEED, 4: maximum speed level; also the maximum number of pulses per frame.
- STAGE_LENGTH, 4096: scroll rows to stage end.
- CRASH_FRAMES, 60: frames spent in CRASH before resuming.
- DIST_W, 16: width of the distance counter; must satisfy 2^DIST_W > STAGE_LENGTH.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- frame_tick  in  1  single-cycle pulse, once per frame, during vertical blank
- start  in  1  pulse; leave IDLE or FINISHED
- pause_toggle  in  1  pulse; RUN↔PAUSED
- speed_up  in  1  pulse; request speed +1
- speed_down  in  1  pulse; request speed −1
- crash  in  1  pulse; player collision
- update_signal  out  1  scroll pulse to the river drawer
- speed  out  3  current speed level, 0..MAX_SPEED
- distance  out  DIST_W  rows scrolled in this stage
- state  out  2  IDLE=0, RUN=1, PAUSED=2, CRASH=3
- stage_done  out  1  level-high while in the finished condition

## Operation
- Reset values:
  - state=IDLE, speed=0, distance=0
  - update_signal=0, stage_done=0
  - burst counter=0, crash frame counter=0
- IDLE:
  - no pulses are emitted.
  - `start` → RUN with speed=1, distance=0, stage_done=0.
- RUN:
  - `speed_up` / `speed_down` change `speed`, saturating at MAX_SPEED / 0. Both in the same cycle: no change.
  - On `frame_tick`, load burst counter = current `speed`.
  - While burst counter>0: assert update_signal, decrement the counter, increment distance.
- Stage end:
  - When distance reaches STAGE_LENGTH, the burst is aborted. stage_done=1 and state=IDLE.
  - distance holds at STAGE_LENGTH.
  - `start` begins a new stage and clears stage_done.
- PAUSED:
  - Entered from RUN on `pause_toggle`; a second `pause_toggle` returns to RUN.
  - Any in-progress burst is discarded immediately and not resumed.
  - speed and distance hold; speed commands are ignored.
- CRASH:
  - Entered from RUN or PAUSED on `crash`. Sets speed=0, aborts any burst, loads crash counter=CRASH_FRAMES.
  - Decrement the crash counter on each `frame_tick`.
  - At 0: go to RUN with speed=1.
  - Pause and speed inputs are ignored.
- Priority within one cycle: reset > crash > stage-end > pause_toggle > frame_tick > speed commands.
  - A `frame_tick` coinciding with a speed command loads the old speed; the new speed takes effect next frame.
  - `crash` in IDLE is ignored.
- Width rules:
  - Burst counter is 3 bits.
  - distance increments with saturation at STAGE_LENGTH and never wraps.
  - speed is never outside 0..MAX_SPEED.

## Timing
- All outputs are registered.
- `frame_tick` at cycle t with speed=N>0: update_signal is high on cycles t+1..t+N, back-to-back.
- distance shows +k one cycle after the k-th pulse.
- A `frame_tick` arriving mid-burst reloads the burst counter with speed. Remaining pulses from the old burst are dropped.
- A pause or crash at cycle t forces update_signal=0 from t+1.
- stage_done rises on the cycle after the final pulse.
- Reset asserted mid-burst clears update_signal asynchronously.

## Structure
- Package `river_pkg`:
  - state encoding constants IDLE/RUN/PAUSED/CRASH
  - MAX_SPEED and the speed width
  - shared by the river drawer and by game logic.
- Sub-module `update_burst_gen`:
  - inputs: load, count, abort
  - output: single-cycle pulse train
  - holds the 3-bit burst counter.
- The top level holds the FSM, the speed register, the distance counter and the crash counter.

## Test plan
- Reset, `start`, 3× `speed_up`, then `frame_tick` → speed=4; update_signal high exactly 4 consecutive cycles after the tick; distance=4.
- speed=2, `pause_toggle` one cycle after `frame_tick` → exactly 1 pulse; state=PAUSED; further ticks give no pulses; second toggle resumes 2 per frame.
- `crash` in RUN with speed=3 → speed=0, state=CRASH; no pulses for 60 ticks; on the 60th tick state=RUN, speed=1; next tick gives 1 pulse.
- STAGE_LENGTH=10, speed=4, three ticks → pulses 4, 4, 2; distance=10; stage_done=1; state=IDLE; later ticks give no pulses.
- `speed_up` at MAX_SPEED and `speed_down` at 0 → saturate. `speed_up` coincident with `frame_tick` at speed 1 → 1 pulse that frame, 2 the next.
- Assert reset mid-burst → update_signal=0 immediately; all outputs return to reset values.

Source files
------------

// File: rtl/river_pkg.sv
// river_pkg: shared scroll-state encoding and speed limits.
// Used by the scroll controller, the river drawer and game logic.
package river_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    CRASH  = 2'd3
  } scroll_state_t;

  localparam int MAX_SPEED = 4;
  localparam int SPEED_W   = 3;

endpackage

// File: rtl/update_burst_gen.sv
// update_burst_gen: turns a loaded count into back-to-back
// single-cycle pulses, one per cycle, abortable at any time.
module update_burst_gen
  import river_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [SPEED_W-1:0] count,
  input  logic               abort,
  output logic               pulse
);

  logic [2:0] cnt;

  // abort wins over load; a load restarts the train with the new count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= 3'd0;
      pulse <= 1'b0;
    end else if (abort) begin
      cnt   <= 3'd0;
      pulse <= 1'b0;
    end else if (load) begin
      pulse <= (count != 3'd0);
      cnt   <= (count != 3'd0) ? count - 3'd1 : 3'd0;
    end else if (cnt != 3'd0) begin
      pulse <= 1'b1;
      cnt   <= cnt - 3'd1;
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/river_scroll_ctrl.sv
// river_scroll_ctrl: frame-driven scroll sequencer for the river layer.
// Holds the FSM, speed, distance and crash slow-down counter.
module river_scroll_ctrl
  import river_pkg::*;
#(
  parameter int MAX_SPEED    = river_pkg::MAX_SPEED,
  parameter int STAGE_LENGTH = 4096,
  parameter int CRASH_FRAMES = 60,
  parameter int DIST_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              pause_toggle,
  input  logic              speed_up,
  input  logic              speed_down,
  input  logic              crash,
  output logic              update_signal,
  output logic [2:0]        speed,
  output logic [DIST_W-1:0] distance,
  output logic [1:0]        state,
  output logic              stage_done
);

  localparam int CW = $clog2(CRASH_FRAMES + 1);
  localparam logic [DIST_W-1:0] LEN   = DIST_W'(STAGE_LENGTH);
  localparam logic [DIST_W-1:0] LEN_M = DIST_W'(STAGE_LENGTH - 1);
  localparam logic [2:0] SMAX = 3'(MAX_SPEED);

  scroll_state_t st;
  logic [CW-1:0] crash_cnt;
  logic crash_go;
  logic stage_hit;
  logic pause_go;
  logic b_load;
  logic b_abort;

  // event decode with crash > stage-end > pause > frame_tick priority
  always_comb begin
    crash_go  = crash && (st == RUN || st == PAUSED);
    stage_hit = (st == RUN) &&
                (distance == LEN ||
                 (update_signal && distance == LEN_M));
    pause_go  = pause_toggle && (st == RUN || st == PAUSED);
    b_abort   = crash_go || stage_hit ||
                (pause_go && st == RUN);
    b_load    = (st == RUN) && frame_tick &&
                !crash_go && !stage_hit && !pause_go;
  end

  update_burst_gen u_burst (
    .clk   (clk),
    .reset (reset),
    .load  (b_load),
    .count (speed),
    .abort (b_abort),
    .pulse (update_signal)
  );

  assign state = st;

  // scroll FSM, speed, saturating distance and crash countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= IDLE;
      speed      <= 3'd0;
      distance   <= '0;
      stage_done <= 1'b0;
      crash_cnt  <= '0;
    end else begin
      if (update_signal && distance != LEN)
        distance <= distance + 1'b1;
      case (st)
        IDLE: begin
          if (start) begin
            st         <= RUN;
            speed      <= 3'd1;
            distance   <= '0;
            stage_done <= 1'b0;
          end
        end
        RUN: begin
          if (crash_go) begin
            st        <= CRASH;
            speed     <= 3'd0;
            crash_cnt <= CW'(CRASH_FRAMES);
          end else if (stage_hit) begin
            st         <= IDLE;
            stage_done <= 1'b1;
            distance   <= LEN;
          end else if (pause_go) begin
            st <= PAUSED;
          end else if (speed_up && !speed_down) begin
            if (speed < SMAX)
              speed <= speed + 3'd1;
          end else if (speed_down && !speed_up) begin
            if (speed != 3'd0)
              speed <= speed - 3'd1;
          end
        end
        PAUSED: begin
          if (crash_go) begin
            st        <= CRASH;
            speed     <= 3'd0;
            crash_cnt <= CW'(CRASH_FRAMES);
          end else if (pause_go) begin
            st <= RUN;
          end
        end
        CRASH: begin
          if (frame_tick) begin
            if (crash_cnt <= CW'(1)) begin
              crash_cnt <= '0;
              st        <= RUN;
              speed     <= 3'd1;
            end else begin
              crash_cnt <= crash_cnt - 1'b1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_river_scroll_ctrl.sv
// tb_river_scroll_ctrl: frame-level reference model with a pulse-run
// scoreboard; random speed/pause/crash/start traffic.
module tb_river_scroll_ctrl;

  localparam int L  = 40;
  localparam int CF = 6;
  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        pause_toggle = 1'b0;
  logic        speed_up = 1'b0;
  logic        speed_down = 1'b0;
  logic        crash = 1'b0;
  logic        update_signal;
  logic [2:0]  speed;
  logic [15:0] distance;
  logic [1:0]  state;
  logic        stage_done;

  river_scroll_ctrl #(
    .MAX_SPEED    (MS),
    .STAGE_LENGTH (L),
    .CRASH_FRAMES (CF),
    .DIST_W       (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .start         (start),
    .pause_toggle  (pause_toggle),
    .speed_up      (speed_up),
    .speed_down    (speed_down),
    .crash         (crash),
    .update_signal (update_signal),
    .speed         (speed),
    .distance      (distance),
    .state         (state),
    .stage_done    (stage_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  bit ignore_run = 0;
  int run_len = 0;

  int m_st = 0;
  int m_spd = 0;
  int m_dist = 0;
  int m_crash = 0;
  int m_done = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // monitor: each completed run of pulses is one frame's burst
  always @(negedge clk) begin
    if (update_signal === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      if (ignore_run)
        ignore_run = 0;
      else if (exp_q.size() == 0)
        chk("unexpected_run", run_len, 0);
      else
        chk("run_len", run_len, exp_q.pop_front());
      run_len = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_st = 0; m_spd = 0; m_dist = 0;
    m_crash = 0; m_done = 0;
    exp_q.delete();
  endtask

  task automatic check_regs(string tag);
    chk({tag, ":state"}, int'(state), m_st);
    chk({tag, ":speed"}, int'(speed), m_spd);
    chk({tag, ":distance"}, int'(distance), m_dist);
    chk({tag, ":stage_done"}, int'(stage_done), m_done);
  endtask

  // cmd bit0=speed_up bit1=speed_down with the tick;
  // pause_at>0 toggles pause that many cycles into the burst;
  // post: 0 none, 1 pause_toggle, 2 crash, 3 start
  task automatic frame(int cmd, int pause_at, int post, string tag);
    int n;
    int pre;
    pre = m_st;
    frame_tick = 1'b1;
    speed_up   = cmd[0];
    speed_down = cmd[1];
    cyc();
    frame_tick = 1'b0;
    speed_up   = 1'b0;
    speed_down = 1'b0;
    if (pre == 1) begin
      n = (m_spd < L - m_dist) ? m_spd : L - m_dist;
      if (pause_at > 0 && pause_at < n) n = pause_at;
      if (n > 0) exp_q.push_back(n);
      m_dist += n;
      if (cmd == 1 && m_spd < MS) m_spd++;
      if (cmd == 2 && m_spd > 0) m_spd--;
      if (m_dist == L) begin
        m_st = 0;
        m_done = 1;
      end else if (pause_at > 0) begin
        m_st = 2;
      end
    end else if (pre == 3) begin
      m_crash--;
      if (m_crash == 0) begin
        m_st = 1;
        m_spd = 1;
      end
    end
    if (pre == 1 && pause_at > 0) begin
      repeat (pause_at - 1) cyc();
      pause_toggle = 1'b1;
      cyc();
      pause_toggle = 1'b0;
    end
    repeat (8) cyc();
    if (post != 0) begin
      pause_toggle = (post == 1);
      crash        = (post == 2);
      start        = (post == 3);
      cyc();
      pause_toggle = 1'b0;
      crash        = 1'b0;
      start        = 1'b0;
      if (post == 1 && m_st == 1) m_st = 2;
      else if (post == 1 && m_st == 2) m_st = 1;
      else if (post == 2 && (m_st == 1 || m_st == 2)) begin
        m_st = 3; m_spd = 0; m_crash = CF;
      end else if (post == 3 && m_st == 0) begin
        m_st = 1; m_spd = 1; m_dist = 0; m_done = 0;
      end
    end
    repeat (2) cyc();
    check_regs(tag);
  endtask

  initial begin
    int r;
    int cmd;
    int pa;
    int post;
    model_reset();
    repeat (3) cyc();
    check_regs("reset");
    chk("reset:update", int'(update_signal), 0);
    reset = 1'b0;
    cyc();

    frame(0, 0, 3, "idle_tick_start");
    frame(1, 0, 0, "up_with_tick1");
    frame(1, 0, 0, "up_with_tick2");
    frame(1, 0, 0, "up_with_tick3");
    frame(0, 0, 0, "speed4_burst");
    frame(1, 0, 0, "sat_max");
    frame(2, 0, 0, "down");
    frame(2, 0, 0, "down2");
    frame(0, 1, 0, "pause_mid_burst");
    frame(0, 0, 0, "paused_tick");
    frame(1, 0, 1, "paused_cmd_resume");
    frame(0, 0, 0, "resumed");
    frame(2, 0, 0, "down3");
    frame(2, 0, 0, "down_to_0");
    frame(2, 0, 0, "sat_zero");
    frame(1, 0, 2, "crash");
    for (int i = 0; i < CF; i++) frame(0, 0, 0, "crash_wait");
    frame(0, 0, 0, "after_crash");

    for (int i = 0; i < 300; i++) begin
      cmd  = int'($urandom_range(0, 3));
      pa   = ($urandom_range(0, 3) == 0) ?
             int'($urandom_range(1, 4)) : 0;
      r    = int'($urandom_range(0, 9));
      post = (r == 0) ? 2 : (r <= 2) ? 1 : (r <= 5) ? 3 : 0;
      if (m_spd < 3 && cmd == 0 && r > 6) cmd = 1;
      frame(cmd, pa, post, "rand");
    end

    repeat (3) cyc();
    chk("queue_drained", exp_q.size(), 0);

    reset = 1'b1;
    cyc();
    model_reset();
    reset = 1'b0;
    cyc();
    frame(0, 0, 3, "rst_start");
    frame(1, 0, 0, "rst_up1");
    frame(1, 0, 0, "rst_up2");
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    chk("midburst:update_before", int'(update_signal), 1);
    ignore_run = 1;
    reset = 1'b1;
    #1;
    chk("midburst:update_async", int'(update_signal), 0);
    model_reset();
    check_regs("midburst_reset");
    cyc();
    reset = 1'b0;
    repeat (6) cyc();
    chk("post_reset:update", int'(update_signal), 0);
    check_regs("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
